// File: rtl/dsp_result_collector.sv
// ---------------------------------------------------------------------------
// dsp_result_collector
//
// Purpose:
//   Response side of the DSP_top operand interface. It watches the same
//   start/mode strobes that drive DSP_top and keeps one token per in-flight
//   operation. It samples dsp_out on the exact edge each result matures and
//   queues {result, tag, mode} in a small ready/valid FIFO. Issue-protocol
//   violations and dropped results raise sticky flags.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   issue strobe (same as DSP_top.start)
//   mode       in   DSP mode (same as DSP_top.mode); 3 is reserved
//   dsp_out    in   DSP_top.out, 2*WIDTH bits
//   clr        in   synchronous clear of seq_err, overflow and tag counter
//   res_data   out  FIFO head result (0 when empty)
//   res_tag    out  FIFO head tag (0 when empty)
//   res_mode   out  FIFO head mode (0 when empty)
//   res_valid  out  FIFO non-empty
//   res_ready  in   consumer pops the head when res_valid && res_ready
//   busy       out  an operation is in flight
//   seq_err    out  sticky issue-protocol violation
//   overflow   out  sticky result dropped on a full FIFO
// ---------------------------------------------------------------------------
module dsp_result_collector #(
    parameter int WIDTH    = 32,
    parameter int PIPE_LAT = 2,
    parameter int DEPTH    = 4,
    parameter int TAG_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [2*WIDTH-1:0]   dsp_out,
    input  logic                 clr,
    output logic [2*WIDTH-1:0]   res_data,
    output logic [TAG_W-1:0]     res_tag,
    output logic [1:0]           res_mode,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 busy,
    output logic                 seq_err,
    output logic                 overflow
);

    localparam int NSTG = PIPE_LAT + 4;
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;

    // Extra issue-blocking cycles per mode.
    function automatic logic [1:0] f_extra(input logic [1:0] m);
        case (m)
            2'd1:    f_extra = 2'd1;
            2'd2:    f_extra = 2'd3;
            default: f_extra = 2'd0;
        endcase
    endfunction

    // A token injected at stage 0 on edge T sits in stage d after edge T+d,
    // so its result (due at edge T+PIPE_LAT+EXTRA) is sampled while it sits
    // one stage earlier than that latency.
    function automatic int f_cap_stage(input logic [1:0] m);
        f_cap_stage = PIPE_LAT + int'(f_extra(m)) - 1;
    endfunction

    // Tracker
    logic [NSTG-1:0]    r_stg_vld;
    logic [1:0]         r_stg_mode [NSTG];
    logic [TAG_W-1:0]   r_stg_tag  [NSTG];
    logic [1:0]         r_win;
    logic [TAG_W-1:0]   r_tag;
    logic               r_seq_err;
    logic               r_ovf;
    logic               r_busy;

    // FIFO
    logic [2*WIDTH-1:0] r_mem_data [DEPTH];
    logic [TAG_W-1:0]   r_mem_tag  [DEPTH];
    logic [1:0]         r_mem_mode [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_cnt;

    logic               w_mix;
    logic               w_cap;
    logic [TAG_W-1:0]   w_cap_tag;
    logic [1:0]         w_cap_mode;
    logic [NSTG-1:0]    w_drop;
    logic               w_win_open;
    logic               w_accept;
    logic               w_reject;
    logic               w_pop;
    logic               w_full;
    logic               w_push;
    logic               w_lost;
    logic [1:0]         w_win_nxt;
    logic               w_busy_nxt;

    // Scan the tracker: mode conflicts against in-flight tokens and the one
    // token (if any) that matures on this edge. Only one can mature per edge
    // because all in-flight tokens share a mode and issue at most once a cycle.
    always_comb begin
        w_mix      = 1'b0;
        w_cap      = 1'b0;
        w_cap_tag  = '0;
        w_cap_mode = '0;
        w_drop     = '0;
        for (int i = 0; i < NSTG; i++) begin
            if (r_stg_vld[i] && (r_stg_mode[i] != mode)) begin
                w_mix = 1'b1;
            end
            if (r_stg_vld[i] && (i == f_cap_stage(r_stg_mode[i]))) begin
                w_cap      = 1'b1;
                w_cap_tag  = r_stg_tag[i];
                w_cap_mode = r_stg_mode[i];
                w_drop[i]  = 1'b1;
            end
        end
    end

    assign w_win_open = (r_win != 2'd0);
    assign w_accept   = start && !w_win_open && (mode != 2'd3) && !w_mix;
    assign w_reject   = start && !w_accept;

    assign w_pop      = (r_cnt != '0) && res_ready;
    assign w_full     = (r_cnt == CW'(DEPTH));
    // A pop frees the slot on the same edge, so a full FIFO still takes it.
    assign w_push     = w_cap && (!w_full || w_pop);
    assign w_lost     = w_cap && w_full && !w_pop;

    assign w_win_nxt  = w_accept ? f_extra(mode)
                      : (w_win_open ? (r_win - 2'd1) : 2'd0);

    // busy stays up through the capture edge and falls on the next one.
    assign w_busy_nxt = w_accept || w_cap || (|(r_stg_vld & ~w_drop))
                      || (w_win_nxt != 2'd0);

    // ---- stage: issue tracking / tracker shift ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg_vld <= '0;
            r_win     <= 2'd0;
            r_tag     <= '0;
            r_seq_err <= 1'b0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_stg_vld[0] <= w_accept;
            for (int i = 1; i < NSTG; i++) begin
                r_stg_vld[i] <= r_stg_vld[i-1] && !w_drop[i-1];
            end
            r_win <= w_win_nxt;
            if (clr) begin
                r_tag <= '0;
            end else if (w_accept) begin
                r_tag <= r_tag + TAG_W'(1);
            end
            // An error on the clr edge still leaves the flag set.
            r_seq_err <= (r_seq_err && !clr) || w_reject;
            r_ovf     <= (r_ovf && !clr) || w_lost;
            r_busy    <= w_busy_nxt;
        end
    end

    always_ff @(posedge clk) begin
        r_stg_mode[0] <= mode;
        r_stg_tag[0]  <= r_tag;
        for (int i = 1; i < NSTG; i++) begin
            r_stg_mode[i] <= r_stg_mode[i-1];
            r_stg_tag[i]  <= r_stg_tag[i-1];
        end
    end

    // ---- stage: result FIFO ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= dsp_out;
            r_mem_tag[r_wr_ptr]  <= w_cap_tag;
            r_mem_mode[r_wr_ptr] <= w_cap_mode;
        end
    end

    // Storage is not reset, so the head is masked to 0 while empty.
    assign res_valid = (r_cnt != '0);
    assign res_data  = res_valid ? r_mem_data[r_rd_ptr] : '0;
    assign res_tag   = res_valid ? r_mem_tag[r_rd_ptr]  : '0;
    assign res_mode  = res_valid ? r_mem_mode[r_rd_ptr] : '0;
    assign busy      = r_busy;
    assign seq_err   = r_seq_err;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_dsp_result_collector.sv
module tb_dsp_result_collector;

    localparam int WIDTH    = 32;
    localparam int PIPE_LAT = 2;
    localparam int DEPTH    = 4;
    localparam int TAG_W    = 8;
    localparam logic [63:0] BASE = 64'h1234_0000_0000_0000;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [1:0]          mode = 2'd0;
    logic [2*WIDTH-1:0]  dsp_out = '0;
    logic                clr = 1'b0;
    logic [2*WIDTH-1:0]  res_data;
    logic [TAG_W-1:0]    res_tag;
    logic [1:0]          res_mode;
    logic                res_valid;
    logic                res_ready = 1'b0;
    logic                busy;
    logic                seq_err;
    logic                overflow;

    dsp_result_collector #(
        .WIDTH(WIDTH), .PIPE_LAT(PIPE_LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .dsp_out(dsp_out), .clr(clr), .res_data(res_data), .res_tag(res_tag),
        .res_mode(res_mode), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .seq_err(seq_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct { int cap; logic [7:0] tag; logic [1:0] md; } op_t;
    typedef struct { logic [63:0] d; logic [7:0] tag; logic [1:0] md; } res_t;

    op_t  pend[$];     // issued ops still waiting for their result edge
    res_t mq[$];       // result FIFO contents, head first
    int   k = 0;       // edge number since reset
    int   last_iss = -100;
    int   last_ext = 0;
    int   m_tag = 0;
    bit   m_seq = 0, m_ovf = 0, m_busy = 0;

    function automatic int extra_of(input logic [1:0] m);
        return (m == 2'd1) ? 1 : (m == 2'd2) ? 3 : 0;
    endfunction

    task automatic model_step();
        bit pop, acc, rej, hit, lost;
        int hi;
        op_t o;
        res_t r;
        if (!rst_n) begin
            pend.delete(); mq.delete();
            k = 0; last_iss = -100; last_ext = 0; m_tag = 0;
            m_seq = 0; m_ovf = 0; m_busy = 0;
            return;
        end
        k++;
        pop = (mq.size() > 0) && res_ready;
        hit = 0; hi = -1; lost = 0;
        foreach (pend[j]) if (pend[j].cap == k) begin hit = 1; hi = j; end
        acc = start && (mode != 2'd3) && (k > last_iss + last_ext);
        foreach (pend[j]) if (pend[j].md != mode) acc = 0;
        rej = start && !acc;
        if (pop) void'(mq.pop_front());
        if (hit) begin
            if (mq.size() < DEPTH) begin
                r.d = dsp_out; r.tag = pend[hi].tag; r.md = pend[hi].md;
                mq.push_back(r);
            end else begin
                lost = 1;
            end
            pend.delete(hi);
        end
        if (acc) begin
            o.cap = k + PIPE_LAT + extra_of(mode);
            o.tag = 8'(m_tag);
            o.md  = mode;
            pend.push_back(o);
            last_iss = k;
            last_ext = extra_of(mode);
            m_tag = (m_tag + 1) % 256;
        end
        if (clr) m_tag = 0;
        m_seq  = (m_seq && !clr) || rej;
        m_ovf  = (m_ovf && !clr) || lost;
        m_busy = acc || hit || (pend.size() > 0);
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    task automatic cmp();
        logic        ev;
        logic [63:0] ed;
        logic [7:0]  et;
        logic [1:0]  em;
        ev = (mq.size() > 0);
        ed = ev ? mq[0].d   : 64'd0;
        et = ev ? mq[0].tag : 8'd0;
        em = ev ? mq[0].md  : 2'd0;
        chk("res_valid", res_valid, ev);
        chk("res_data",  res_data,  ed);
        chk("res_tag",   res_tag,   et);
        chk("res_mode",  res_mode,  em);
        chk("busy",      busy,      m_busy);
        chk("seq_err",   seq_err,   m_seq);
        chk("overflow",  overflow,  m_ovf);
    endtask

    initial forever begin
        @(negedge clk);
        cmp();
    end

    // ---------------- stimulus ----------------
    logic [63:0] gd[8];
    logic [7:0]  gt[8];
    logic [1:0]  gm[8];
    int          n;

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; mode = 2'd0; clr = 1'b0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic grab();
        if (res_valid && n < 8) begin
            gd[n] = res_data; gt[n] = res_tag; gm[n] = res_mode;
        end
        if (res_valid) n++;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_seq", seq_err, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_data", res_data, 0);
        chk("rst_tag", res_tag, 0);
        do_reset();

        // Mode 0 burst of 5
        res_ready = 1'b1; n = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            grab();
            if (i == 7) chk("t1_busy_last_cap", busy, 1);
            if (i == 8) chk("t1_busy_fall", busy, 0);
            start = (i < 5); mode = 2'd0; dsp_out = BASE + 64'(i);
        end
        chk("t1_count", n, 5);
        for (int i = 0; i < 5; i++) begin
            chk("t1_tag", gt[i], i);
            chk("t1_data", gd[i], BASE + 64'(i + 2));
        end

        // Mode 2 every 4 cycles plus an early illegal start
        do_reset();
        res_ready = 1'b1; n = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            grab();
            if (i == 3) chk("t2_seq_err", seq_err, 1);
            start = (i == 0 || i == 2 || i == 4 || i == 8); mode = 2'd2;
            dsp_out = BASE + 64'(i);
        end
        chk("t2_count", n, 3);
        chk("t2_d0", gd[0], BASE + 64'd5);
        chk("t2_d1", gd[1], BASE + 64'd9);
        chk("t2_d2", gd[2], BASE + 64'd13);
        chk("t2_tag2", gt[2], 2);
        chk("t2_mode", gm[1], 2);

        // Mode 1 in flight, then a mode 0 start
        do_reset();
        res_ready = 1'b1; n = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            grab();
            start = (i == 0 || i == 2); mode = (i == 2) ? 2'd0 : 2'd1;
            dsp_out = BASE + 64'(i);
        end
        chk("t3_count", n, 1);
        chk("t3_data", gd[0], BASE + 64'd3);
        chk("t3_mode", gm[0], 1);
        chk("t3_seq_err", seq_err, 1);

        // Overflow with consumer stalled
        do_reset();
        n = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            start = (i < 6); mode = 2'd0; dsp_out = BASE + 64'(i);
        end
        start = 1'b0;
        chk("t4_ovf", overflow, 1);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            grab();
            res_ready = 1'b1;
        end
        chk("t4_count", n, 4);
        for (int i = 0; i < 4; i++) chk("t4_tag", gt[i], i);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        chk("t4_clr_ovf", overflow, 0);

        // Full FIFO with a pop on the capture edge
        do_reset();
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start = (i < 4 || i == 6); mode = 2'd0; res_ready = (i == 8);
            dsp_out = BASE + 64'(i);
        end
        start = 1'b0;
        chk("t5_ovf", overflow, 0);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            grab();
            res_ready = 1'b1;
        end
        chk("t5_count", n, 4);
        chk("t5_tag_first", gt[0], 1);
        chk("t5_tag_last", gt[3], 4);

        // Randomized traffic against the model
        do_reset();
        begin
            logic [1:0] cur_mode;
            cur_mode = 2'd0;
            for (int i = 0; i < 1500; i++) begin
                @(negedge clk);
                if ($urandom_range(7) == 0) cur_mode = 2'($urandom_range(3));
                start     = ($urandom_range(2) != 0);
                mode      = ($urandom_range(15) == 0) ? 2'($urandom_range(3)) : cur_mode;
                res_ready = (i < 750) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
                clr       = !start && ($urandom_range(40) == 0);
                dsp_out   = {$urandom, $urandom};
            end
        end

        // Tag wrap, then reset mid-burst
        do_reset();
        res_ready = 1'b1; n = 0;
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            if (res_valid) begin
                if (n == 255) chk("wrap_tag255", res_tag, 255);
                if (n == 256) chk("wrap_tag0", res_tag, 0);
                n++;
            end
            start = 1'b1; mode = 2'd0; dsp_out = {$urandom, $urandom};
        end
        chk("wrap_count", n, 257);
        #2 rst_n = 1'b0; start = 1'b0;
        #1;
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data", res_data, 0);
        chk("mid_rst_tag", res_tag, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (res_valid) n++;
        end
        chk("no_stale", n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
